// File: rtl/cp0_exc_ctrl.sv
// CP0 interrupt/exception controller: Status/Cause/EPC, irq sync,
// exception/eret/interrupt redirect. CP0_TIMER_EN adds Count/Compare.
module cp0_exc_ctrl #(
  parameter int          N_IRQ       = 6,
  parameter logic [31:0] VECTOR      = 32'h0000_0070,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [31:0]      Pc,
  input  logic [N_IRQ-1:0] IntReq,
  input  logic             ExcOv,
  input  logic             ExcRi,
  input  logic             ExcSys,
  input  logic             Mfc0,
  input  logic             Mtc0,
  input  logic             Eret,
  input  logic [4:0]       Rd,
  input  logic [31:0]      WData,
  output logic [31:0]      RData,
  output logic             Redirect,
  output logic [31:0]      RedirectPc,
  output logic             Kill,
  output logic [N_IRQ-1:0] IntAck,
  output logic [31:0]      Status,
  output logic [31:0]      Cause,
  output logic [31:0]      Epc
);

  localparam logic [7:0] LINE_MASK =
    8'((9'd1 << N_IRQ) - 9'd1);
`ifdef CP0_TIMER_EN
  localparam logic [7:0] IP_MASK = LINE_MASK | 8'h80;
`else
  localparam logic [7:0] IP_MASK = LINE_MASK;
`endif

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] sync_d;
  logic             ie;
  logic             exl;
  logic [7:0]       im;
  logic [7:0]       ip;
  logic [7:0]       ip_nx;
  logic [7:0]       keep;
  logic [7:0]       set_b;
  logic [7:0]       pend;
  logic [7:0]       pick;
  logic [4:0]       code;
  logic [31:0]      epc;
  logic             exc;
  logic             take;
  logic             wr;

  assign exc  = ExcRi | ExcOv | ExcSys;
  assign pend = ip & im;
  // isolate lowest set bit: lowest index wins
  assign pick = pend & (~pend + 8'd1);
  assign take = ie & ~exl & (|pick) & ~exc & ~Eret;

  assign Redirect   = exc | Eret | take;
  assign Kill       = exc | take;
  assign RedirectPc = (Eret && !exc) ? epc : VECTOR;
  assign wr         = Mtc0 & ~Redirect;

  assign Status = {16'h0, im, 6'h0, exl, ie};
  assign Cause  = {16'h0, ip, 1'b0, code, 2'b00};
  assign Epc    = epc;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] count_nx;
  logic        hit;

  assign count_nx = (wr && Rd == 5'd9) ? WData
                                       : count + 32'd1;
  assign hit = (compare != 32'd0) && (count_nx == compare);

  // Count free-runs; an mtc0 overrides the increment
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      count   <= '0;
      compare <= '0;
    end else begin
      count <= count_nx;
      if (wr && Rd == 5'd11) compare <= WData;
    end
  end
`endif

  // Pending update: software clears via mask, new edges win
  always_comb begin
    keep  = 8'hFF;
    set_b = 8'(sync_q[SYNC_STAGES-1] & ~sync_d);
    if (wr && Rd == 5'd29) keep = WData[15:8];
`ifdef CP0_TIMER_EN
    if (wr && Rd == 5'd11) keep[7] = 1'b0;
    set_b[7] = hit;
`endif
    ip_nx = ((ip & keep) | set_b) & IP_MASK;
  end

  // mfc0 read mux, returns pre-edge values
  always_comb begin
    RData = '0;
    if (Mfc0) begin
      case (Rd)
        5'd28:   RData = Status;
        5'd29:   RData = Cause;
        5'd30:   RData = epc;
`ifdef CP0_TIMER_EN
        5'd9:    RData = count;
        5'd11:   RData = compare;
`endif
        default: RData = '0;
      endcase
    end
  end

  // Interrupt line synchronizers plus edge-detect history
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
      sync_d <= '0;
    end else begin
      sync_q[0] <= IntReq;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  // CP0 state: exception > eret > interrupt > mtc0
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      ie     <= 1'b0;
      exl    <= 1'b0;
      im     <= '0;
      ip     <= '0;
      code   <= '0;
      epc    <= '0;
      IntAck <= '0;
    end else begin
      ip     <= ip_nx;
      IntAck <= take ? pick[N_IRQ-1:0] : '0;
      if (exc) begin
        if (ExcRi)      code <= 5'd10;
        else if (ExcOv) code <= 5'd12;
        else            code <= 5'd8;
        if (!exl) begin
          if (ExcRi || ExcOv) epc <= Pc;
          else                epc <= Pc + 32'd4;
        end
        exl <= 1'b1;
      end else if (Eret) begin
        exl <= 1'b0;
      end else if (take) begin
        epc  <= Pc;
        code <= 5'd0;
        exl  <= 1'b1;
      end else if (wr && Rd == 5'd28) begin
        ie  <= WData[0];
        exl <= WData[1];
        im  <= WData[15:8];
      end else if (wr && Rd == 5'd30) begin
        epc <= WData;
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed plan plus random traffic,
// scoreboarded against a cycle-level reference model.
module tb_cp0_exc_ctrl;
  localparam int          N   = 6;
  localparam logic [31:0] VEC = 32'h70;

  logic          Clk = 1'b0;
  logic          Clrn;
  logic [31:0]   Pc;
  logic [N-1:0]  IntReq;
  logic          ExcOv, ExcRi, ExcSys, Mfc0, Mtc0, Eret;
  logic [4:0]    Rd;
  logic [31:0]   WData, RData, RedirectPc;
  logic [31:0]   Status, Cause, Epc;
  logic          Redirect, Kill;
  logic [N-1:0]  IntAck;

  cp0_exc_ctrl #(
    .N_IRQ(N), .VECTOR(VEC), .SYNC_STAGES(2)
  ) dut (
    .Clk(Clk), .Clrn(Clrn), .Pc(Pc), .IntReq(IntReq),
    .ExcOv(ExcOv), .ExcRi(ExcRi), .ExcSys(ExcSys),
    .Mfc0(Mfc0), .Mtc0(Mtc0), .Eret(Eret), .Rd(Rd),
    .WData(WData), .RData(RData), .Redirect(Redirect),
    .RedirectPc(RedirectPc), .Kill(Kill), .IntAck(IntAck),
    .Status(Status), .Cause(Cause), .Epc(Epc)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic         redir;
    logic         kill;
    logic [31:0]  rpc;
    logic [31:0]  rdata;
    logic [31:0]  st;
    logic [31:0]  ca;
    logic [31:0]  ep;
    logic [N-1:0] ack;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  bit         m_ie, m_exl;
  bit [7:0]   m_im, m_ip;
  bit [4:0]   m_code;
  bit [31:0]  m_epc, m_cnt, m_cmp;
  bit [N-1:0] m_ack;
  bit [N-1:0] hist[$];

  function automatic void model_reset();
    m_ie = 0; m_exl = 0; m_im = 0; m_ip = 0;
    m_code = 0; m_epc = 0; m_ack = 0;
    m_cnt = 0; m_cmp = 0;
    hist.delete();
    repeat (4) hist.push_back('0);
  endfunction

  // One instruction cycle of the architectural model
  function automatic void model_cycle();
    exp_t      e;
    bit        exc, take, wr;
    bit [7:0]  pend, keep, rise, ip_n;
    bit [31:0] st, ca;
    int        pick;
    st = {16'h0, m_im, 6'h0, m_exl, m_ie};
    ca = {16'h0, m_ip, 1'b0, m_code, 2'b00};
    e.st = st; e.ca = ca; e.ep = m_epc; e.ack = m_ack;
    e.rdata = 0;
    if (Mfc0) begin
      if (Rd == 28) e.rdata = st;
      else if (Rd == 29) e.rdata = ca;
      else if (Rd == 30) e.rdata = m_epc;
`ifdef CP0_TIMER_EN
      else if (Rd == 9) e.rdata = m_cnt;
      else if (Rd == 11) e.rdata = m_cmp;
`endif
    end
    exc  = ExcRi || ExcOv || ExcSys;
    pend = m_ip & m_im;
    pick = -1;
    for (int i = 7; i >= 0; i--) if (pend[i]) pick = i;
    take = !exc && !Eret && m_ie && !m_exl && pick >= 0;
    e.redir = exc || Eret || take;
    e.kill  = exc || take;
    e.rpc   = (Eret && !exc) ? m_epc : VEC;
    sbq.push_back(e);
    // a line registers as pending when it was high two
    // cycles ago and low three cycles ago
    hist.push_back(IntReq);
    rise = 8'(hist[hist.size()-3] & ~hist[hist.size()-4]);
    if (hist.size() > 8) void'(hist.pop_front());
    wr   = Mtc0 && !e.redir;
    keep = (wr && Rd == 29) ? WData[15:8] : 8'hFF;
`ifdef CP0_TIMER_EN
    begin
      bit [31:0] cnt_n;
      cnt_n = (wr && Rd == 9) ? WData : m_cnt + 1;
      if (m_cmp != 0 && cnt_n == m_cmp) rise[7] = 1;
      if (wr && Rd == 11) begin
        keep[7] = 0;
        m_cmp = WData;
      end
      m_cnt = cnt_n;
    end
    ip_n = ((m_ip & keep) | rise) & 8'hBF;
`else
    ip_n = ((m_ip & keep) | rise) & 8'h3F;
`endif
    m_ack = '0;
    if (take && pick < N) m_ack[pick] = 1;
    if (exc) begin
      if (!m_exl) m_epc = (!ExcRi && !ExcOv) ? Pc + 4 : Pc;
      m_code = ExcRi ? 5'd10 : ExcOv ? 5'd12 : 5'd8;
      m_exl = 1;
    end else if (Eret) begin
      m_exl = 0;
    end else if (take) begin
      m_epc = Pc; m_code = 0; m_exl = 1;
    end else if (wr && Rd == 28) begin
      m_ie = WData[0]; m_exl = WData[1]; m_im = WData[15:8];
    end else if (wr && Rd == 30) begin
      m_epc = WData;
    end
    m_ip = ip_n;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    ExcOv = 0; ExcRi = 0; ExcSys = 0;
    Mfc0 = 0; Mtc0 = 0; Eret = 0; Rd = 0; WData = 0;
  endtask

  task automatic step();
    model_cycle();
    cyc++;
    @(negedge Clk); #1;
  endtask

  task automatic wr_cp0(input logic [4:0] r,
                        input logic [31:0] d);
    idle(); Mtc0 = 1; Rd = r; WData = d;
    step();
    idle();
  endtask

  function automatic logic [4:0] pick_rd();
    case ($urandom_range(0, 5))
      0: return 5'd28;
      1: return 5'd29;
      2: return 5'd30;
      3: return 5'd9;
      4: return 5'd11;
      default: return 5'($urandom);
    endcase
  endfunction

  // Monitor: compare every presented cycle against the queue
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk); #3;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        tests++;
        if (Redirect !== e.redir || Kill !== e.kill ||
            RedirectPc !== e.rpc || RData !== e.rdata ||
            Status !== e.st || Cause !== e.ca ||
            Epc !== e.ep || IntAck !== e.ack) begin
          fails++;
          $display({"FAIL out t=%0t got r%b k%b pc%h rd%h ",
                    "st%h ca%h ep%h ack%b want r%b k%b pc%h ",
                    "rd%h st%h ca%h ep%h ack%b"}, $time,
                   Redirect, Kill, RedirectPc, RData, Status,
                   Cause, Epc, IntAck, e.redir, e.kill, e.rpc,
                   e.rdata, e.st, e.ca, e.ep, e.ack);
        end
      end
    end
  end

  initial begin
    Clrn = 0; Pc = 0; IntReq = 0;
    idle();
    model_reset();
    @(negedge Clk); #1;
    check("por_status", Status, 0);
    Clrn = 1;

    // reset after Status was written
    wr_cp0(28, 32'h1);
    check("status_set", Status, 32'h1);
    Clrn = 0; #1;
    check("rst_status", Status, 0);
    check("rst_cause", Cause, 0);
    check("rst_epc", Epc, 0);
    check("rst_ack", 32'(IntAck), 0);
    check("rst_redir", 32'(Redirect), 0);
    Clrn = 1;
    model_reset();

    // interrupt on line 1
    wr_cp0(28, 32'h0201);
    Pc = 32'h24; IntReq = 6'b000010;
    step(); step(); IntReq = 0; step();
    check("irq_redir", 32'(Redirect), 1);
    check("irq_rpc", RedirectPc, 32'h70);
    check("irq_kill", 32'(Kill), 1);
    step();
    check("irq_epc", Epc, 32'h24);
    check("irq_status", Status, 32'h0203);
    check("irq_cause", Cause, 32'h0200);
    check("irq_ack", 32'(IntAck), 32'h2);
    wr_cp0(29, 0);
    Pc = 32'h30; Eret = 1; step(); Eret = 0;

    // overflow then nested reserved instruction
    Pc = 32'h38; ExcOv = 1; step(); ExcOv = 0;
    check("ov_epc", Epc, 32'h38);
    check("ov_code", 32'(Cause[6:2]), 12);
    Pc = 32'h50; ExcRi = 1; step(); ExcRi = 0;
    check("ri_epc", Epc, 32'h38);
    check("ri_code", 32'(Cause[6:2]), 10);
    Eret = 1; step(); Eret = 0;

    // syscall returns past itself
    Pc = 32'h40; ExcSys = 1; step(); ExcSys = 0;
    check("sys_epc", Epc, 32'h44);
    check("sys_code", 32'(Cause[6:2]), 8);
    Eret = 1; step(); Eret = 0;

    // eret with a pending interrupt
    wr_cp0(30, 32'h24);
    wr_cp0(28, 32'h0103);
    IntReq = 6'b000001;
    step(); step(); IntReq = 0; step(); step();
    check("pend_ip0", 32'(Cause[8]), 1);
    Pc = 32'h60; Eret = 1; #1;
    check("eret_redir", 32'(Redirect), 1);
    check("eret_rpc", RedirectPc, 32'h24);
    check("eret_kill", 32'(Kill), 0);
    step(); Eret = 0; Pc = 32'h28; #1;
    check("post_redir", 32'(Redirect), 1);
    check("post_kill", 32'(Kill), 1);
    step();
    check("post_epc", Epc, 32'h28);
    check("post_ack", 32'(IntAck), 1);

    // clear racing a new edge
    IntReq = 6'b000100;
    step(); step(); IntReq = 0;
    Mtc0 = 1; Rd = 29; WData = 0;
    step(); idle();
    check("clr_race", 32'(Cause[15:8]), 32'h04);
    Eret = 1; step(); Eret = 0;

`ifdef CP0_TIMER_EN
    wr_cp0(11, 5);
    wr_cp0(9, 0);
    repeat (5) step();
    check("tmr_ip15", 32'(Cause[15]), 1);
`endif

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int r;
      idle();
      Pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) IntReq = N'($urandom);
      r = $urandom_range(0, 99);
      if (r < 3) ExcOv = 1;
      else if (r < 5) ExcRi = 1;
      else if (r < 7) ExcSys = 1;
      else if (r < 14) Eret = 1;
      else if (r < 36) begin
        Mtc0 = 1; Rd = pick_rd(); WData = $urandom;
      end
      if (!Mtc0 && $urandom_range(0, 1) == 1) begin
        Mfc0 = 1; Rd = pick_rd();
      end
      if ($urandom_range(0, 49) == 0) ExcRi = 1;
      step();
    end

    idle(); IntReq = 0;
    repeat (3) step();
    @(negedge Clk); #4;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 style interrupt/exception controller for the single-cycle MIPS core.
- Synchronizes external interrupt lines and latches them as pending.
- Each cycle, decides whether to take an exception, take an interrupt, return (eret), or run normally; drives a PC redirect and an instruction kill to the fetch/writeback path.
- Holds the Status, Cause and EPC registers read and written by mfc0/mtc0. The handler vector is the instruction-memory reserved region at byte address 0x70.

Parameters:
- N_IRQ, 6, number of external interrupt lines (1..7); line i maps to Cause.IP[8+i].
- VECTOR, 32'h00000070, handler entry address.
- SYNC_STAGES, 2, flop stages on each interrupt line (at least 2).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Clrn  in  1  asynchronous active-low reset.
- Pc  in  32  address of the instruction in the current cycle.
- IntReq  in  N_IRQ  asynchronous interrupt lines, active-high.
- ExcOv  in  1  arithmetic overflow in the current instruction.
- ExcRi  in  1  reserved/illegal opcode in the current instruction.
- ExcSys  in  1  syscall in the current instruction.
- Mfc0  in  1  current instruction is mfc0.
- Mtc0  in  1  current instruction is mtc0.
- Eret  in  1  current instruction is eret.
- Rd  in  5  CP0 register select.
- WData  in  32  mtc0 data (rt value).
- RData  out  32  mfc0 read data (combinational).
- Redirect  out  1  next PC equals RedirectPc (combinational).
- RedirectPc  out  32  VECTOR or EPC.
- Kill  out  1  suppress register/memory writes of the current instruction.
- IntAck  out  N_IRQ  one-hot, one-cycle pulse of the interrupt taken.
- Status  out  32  Status register.
- Cause  out  32  Cause register.
- Epc  out  32  EPC register.

Behaviour:
- Reset (Clrn=0, async): Status=0, Cause=0, Epc=0, sync flops=0, pending=0, IntAck=0.
- CP0 register map:
  - Rd=28: Status. bit0 IE, bit1 EXL, bits[15:8] IM; other bits read 0.
  - Rd=29: Cause. bits[15:8] IP, bits[6:2] ExcCode; other bits 0.
  - Rd=30: EPC.
  - Any other Rd reads 0; mtc0 to it is ignored.
- Pending: IP[8+i] sets on a 0→1 edge of synchronized IntReq[i] and stays set until software clears it.
  - mtc0 Cause computes IP <= IP & WData[15:8]; other Cause fields are not writable.
  - If a set edge and a clear hit the same bit in the same cycle, set wins.
  - IP bits at or above 8+N_IRQ read 0 (except bit 15 under the optional feature).
- Priority each cycle (first match applies):
  - 1. Exception (ExcRi > ExcOv > ExcSys):
    - Combinationally: Redirect=1, RedirectPc=VECTOR, Kill=1.
    - At the edge: ExcCode <= 10 (Ri), 12 (Ov) or 8 (Sys).
    - If EXL=0: Epc <= Pc (Ri/Ov) or Pc+4 (Sys). If EXL=1, Epc is unchanged.
    - EXL <= 1.
  - 2. Eret:
    - Redirect=1, RedirectPc=Epc, Kill=0.
    - EXL <= 0 at the edge. The same behaviour applies even if EXL is already 0.
  - 3. Interrupt, taken when IE=1, EXL=0 and (IP & IM) != 0:
    - Selects the lowest set index i.
    - Redirect=1, RedirectPc=VECTOR, Kill=1; the instruction at Pc is not executed.
    - At the edge: Epc <= Pc, ExcCode <= 0, EXL <= 1.
    - IntAck[i] pulses for the cycle after the edge. IP is not auto-cleared.
  - 4. None: Redirect=0, Kill=0, normal mtc0 writes apply.
- Kill=1 also suppresses any mtc0 in the same cycle. Interrupt evaluation always uses pre-edge Status.
- An interrupt cannot be taken in an eret cycle (EXL is still 1 then). The earliest it can be taken is the next cycle.
- mtc0 Status writes bits 0, 1 and [15:8] only.
- RData returns the pre-edge register value; mfc0 of a register written by mtc0 in the same cycle returns the old value.
- Latency: IntReq edge to Redirect is SYNC_STAGES+1 cycles.

Optional Feature:
- Macro CP0_TIMER_EN.
- When defined:
  - Rd=9 is Count; it increments every cycle, wraps 0xFFFFFFFF→0, and is writable by mtc0.
  - Rd=11 is Compare.
  - When Count==Compare (post-increment, Compare≠0), IP[15] sets.
  - mtc0 to Compare clears IP[15].
  - IP[15] follows the normal IM[7] masking and has the lowest interrupt priority.
- When undefined: Rd=9 and Rd=11 read 0, writes are ignored, and IP[15] is always 0.

Test Plan:
- Reset with Status=1 set beforehand → all outputs 0, Redirect=0.
- Status=0x0201, pulse IntReq[1] with Pc=0x24 → 3 cycles later Redirect=1, RedirectPc=0x70, Kill=1. Next: Epc=0x24, Status=0x0203, Cause=0x0200, IntAck=0b10.
- ExcOv at Pc=0x38 with EXL=0 → Epc=0x38, ExcCode=12. A second ExcRi while EXL=1 → Epc stays 0x38, ExcCode=10.
- ExcSys at Pc=0x40 → Epc=0x44, Cause[6:2]=8.
- Eret with Epc=0x24 and IntReq[0] pending with IM0 set → cycle 1: RedirectPc=0x24, no interrupt taken. Cycle 2: interrupt taken, Epc=Pc of cycle 2.
- mtc0 Cause WData=0 while IntReq[2] rises in the same cycle → IP[10] remains 1 and other IP bits clear. With CP0_TIMER_EN: Compare=5, Count=0 → IP[15]=1 at Count=5.
